iic_slave: RTL and testbench

- I2C responder (slave) matching the team's IIC master controller, for FPGA-side register banks that must be reachable over the same two-wire bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a fixed 7-bit device address.
- Accepts register-address and data bytes and drives ACK and read data onto the open-drain SDA.
- Fronts an external register bank through a simple address/write-strobe/read-data interface, with register-pointer auto-increment.

---
 rtl/iic_pkg.sv | 21 ++
 rtl/iic_line_sync.sv | 53 +++++
 rtl/iic_slave.sv | 198 +++++++++++++++++++
 tb/tb_iic_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared I2C definitions: responder state encoding and R/W bit values.
// The R/W constants are also used by the master controller.
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } iic_state_e;

  localparam logic RW_WR = 1'b0;
  localparam logic RW_RD = 1'b1;

endpackage

// File: rtl/iic_line_sync.sv
// Synchronises scl/sda, keeps one history flop and flags edges and bus
// conditions one cycle after the synchronised value changes.
module iic_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_hist_reg;
  logic                   sda_hist_reg;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync_reg[SYNC_STAGES-1];
  assign sda_now = sda_sync_reg[SYNC_STAGES-1];

  // Lines reset to the idle (released, pulled-up) level so no false edge
  // is seen when reset is removed on a quiet bus.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_hist_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
      scl_rise     <= 1'b0;
      scl_fall     <= 1'b0;
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
      sda_s        <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda};
      scl_hist_reg <= scl_now;
      sda_hist_reg <= sda_now;
      scl_rise     <= scl_now & ~scl_hist_reg;
      scl_fall     <= ~scl_now & scl_hist_reg;
      start_det    <= scl_now & scl_hist_reg & sda_hist_reg & ~sda_now;
      stop_det     <= scl_now & scl_hist_reg & ~sda_hist_reg & sda_now;
      sda_s        <= sda_now;
    end
  end

endmodule

// File: rtl/iic_slave.sv
// I2C responder fronting a register bank: fixed device address, register
// pointer with auto-increment, ACKs every byte after an address match.
module iic_slave #(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr_o,
  output logic [7:0] wr_data_o,
  output logic       wr_en_o,
  input  logic [7:0] rd_data_i,
  output logic       rd_req_o,
  output logic       busy_o
);

  import iic_pkg::*;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  iic_state_e state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] reg_addr_reg, reg_addr_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic       wr_en_reg, wr_en_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       busy_reg, busy_next;
  logic       rw_reg, rw_next;
  logic       mack_ok_reg, mack_ok_next;
  logic       rd_req;
  logic [7:0] shift_in;

  assign shift_in = {shift_reg[6:0], sda_s};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      reg_addr_reg <= '0;
      wr_data_reg  <= '0;
      wr_en_reg    <= 1'b0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      rw_reg       <= RW_WR;
      mack_ok_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      reg_addr_reg <= reg_addr_next;
      wr_data_reg  <= wr_data_next;
      wr_en_reg    <= wr_en_next;
      sda_oe_reg   <= sda_oe_next;
      busy_reg     <= busy_next;
      rw_reg       <= rw_next;
      mack_ok_reg  <= mack_ok_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    reg_addr_next = reg_addr_reg;
    wr_data_next  = wr_data_reg;
    wr_en_next    = 1'b0;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    mack_ok_next  = mack_ok_reg;
    rd_req        = 1'b0;

    // Pointer advances the cycle after a write strobe.
    if (wr_en_reg) reg_addr_next = reg_addr_reg + 8'd1;

    if (stop_det) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else begin
      unique case (state_reg)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = shift_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
          if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = '0;
            sda_oe_next  = 1'b1;
            if (state_reg == ST_ADDR) begin
              if (shift_reg[7:1] == SLV_ADDR) begin
                busy_next  = 1'b1;
                rw_next    = shift_reg[0];
                state_next = ST_ADDR_ACK;
              end else begin
                sda_oe_next = 1'b0;
                busy_next   = 1'b0;
                state_next  = ST_IGNORE;
              end
            end else if (state_reg == ST_REG) begin
              reg_addr_next = shift_reg;
              state_next    = ST_REG_ACK;
            end else begin
              wr_data_next = shift_reg;
              wr_en_next   = 1'b1;
              state_next   = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            if (rw_reg == RW_WR) begin
              state_next = ST_REG;
            end else begin
              rd_req       = 1'b1;
              shift_next   = rd_data_i;
              sda_oe_next  = ~rd_data_i[7];
              bit_cnt_next = 4'd1;
              state_next   = ST_RDATA;
            end
          end
        end
        ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            state_next  = ST_WDATA;
          end
        end
        // bit_cnt counts bits already placed on the line.
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next   = 1'b0;
              reg_addr_next = reg_addr_reg + 8'd1;
              mack_ok_next  = 1'b0;
              bit_cnt_next  = '0;
              state_next    = ST_MACK;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_oe_next  = ~shift_reg[6];
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              mack_ok_next = 1'b1;
            end else begin
              busy_next  = 1'b0;
              state_next = ST_IGNORE;
            end
          end else if (scl_fall && mack_ok_reg) begin
            rd_req       = 1'b1;
            shift_next   = rd_data_i;
            sda_oe_next  = ~rd_data_i[7];
            bit_cnt_next = 4'd1;
            state_next   = ST_RDATA;
          end
        end
        default: begin
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  assign sda        = sda_oe_reg ? 1'b0 : 1'bz;
  assign reg_addr_o = reg_addr_reg;
  assign wr_data_o  = wr_data_reg;
  assign wr_en_o    = wr_en_reg;
  assign rd_req_o   = rd_req;
  assign busy_o     = busy_reg;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: bit-banged I2C master, register-bank model
// and a strobe log sampled on the falling system-clock edge.
module tb_iic_slave;

  localparam int QTR = 10;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       scl = 1'b1;
  logic       master_oe = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr_o, wr_data_o, rd_data_i;
  logic       wr_en_o, rd_req_o, busy_o;
  logic [7:0] bank [256];

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [15:0] wr_log[$];
  int         rd_req_cnt = 0;

  always #5 clk_i = ~clk_i;

  assign sda_bus = master_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign rd_data_i = bank[reg_addr_o];

  iic_slave #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl       (scl),
    .sda       (sda_bus),
    .reg_addr_o(reg_addr_o),
    .wr_data_o (wr_data_o),
    .wr_en_o   (wr_en_o),
    .rd_data_i (rd_data_i),
    .rd_req_o  (rd_req_o),
    .busy_o    (busy_o)
  );

  always @(negedge clk_i) begin
    if (wr_en_o) wr_log.push_back({reg_addr_o, wr_data_o});
    if (rd_req_o) rd_req_cnt = rd_req_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_q();
    repeat (QTR) @(negedge clk_i);
  endtask

  // One SCL clock starting and ending with scl low; returns sda sampled mid-high.
  task automatic send_bit(input logic b, output logic got);
    wait_q();
    master_oe = ~b;
    wait_q();
    scl = 1'b1;
    wait_q();
    got = sda_bus;
    wait_q();
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    master_oe = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    master_oe = 1'b1;
    wait_q();
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q();
    master_oe = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    master_oe = 1'b0;
    wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] data);
    logic bit_v, dummy;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, bit_v);
      data[i] = bit_v;
    end
    send_bit(~master_ack, dummy);
  endtask

  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] rbyte;
    int         base;
    int         rd_base;

    for (int i = 0; i < 256; i++) bank[i] = 8'(i) ^ 8'h5A;
    bank[8'h40] = 8'h3C;
    bank[8'h41] = 8'hC3;

    // Reset state
    repeat (5) @(negedge clk_i);
    check_val("rst_reg_addr", 32'(reg_addr_o), 32'h00);
    check_val("rst_wr_data", 32'(wr_data_o), 32'h00);
    check_val("rst_wr_en", 32'(wr_en_o), 32'h0);
    check_val("rst_rd_req", 32'(rd_req_o), 32'h0);
    check_val("rst_busy", 32'(busy_o), 32'h0);
    check_val("rst_sda", 32'(sda_bus), 32'h1);
    rst_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Single-byte write: 0x50 W, reg 0x12, data 0xA5
    base = wr_log.size();
    i2c_start();
    write_byte(8'hA0, ack);
    check_val("wr1_addr_ack", 32'(ack), 32'h0);
    check_val("wr1_busy", 32'(busy_o), 32'h1);
    write_byte(8'h12, ack);
    check_val("wr1_reg_ack", 32'(ack), 32'h0);
    write_byte(8'hA5, ack);
    check_val("wr1_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    check_val("wr1_strobes", 32'(wr_log.size() - base), 32'd1);
    check_val("wr1_strobe0", 32'(wr_log[base]), 32'h12A5);
    check_val("wr1_ptr", 32'(reg_addr_o), 32'h13);
    check_val("wr1_busy_stop", 32'(busy_o), 32'h0);

    // Burst write wrapping the pointer
    base = wr_log.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFE, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    write_byte(8'h33, ack);
    check_val("burst_last_ack", 32'(ack), 32'h0);
    i2c_stop();
    check_val("burst_strobes", 32'(wr_log.size() - base), 32'd3);
    check_val("burst_strobe0", 32'(wr_log[base]), 32'hFE11);
    check_val("burst_strobe1", 32'(wr_log[base+1]), 32'hFF22);
    check_val("burst_strobe2", 32'(wr_log[base+2]), 32'h0033);
    check_val("burst_ptr", 32'(reg_addr_o), 32'h01);

    // Random read: reg 0x40, repeated START, two bytes
    base = wr_log.size();
    rd_base = rd_req_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    check_val("rd_reg_ack", 32'(ack), 32'h0);
    i2c_start();
    write_byte(8'hA1, ack);
    check_val("rd_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b1, rbyte);
    check_val("rd_byte0", 32'(rbyte), 32'h3C);
    read_byte(1'b0, rbyte);
    check_val("rd_byte1", 32'(rbyte), 32'hC3);
    wait_q();
    check_val("rd_sda_released", 32'(sda_bus), 32'h1);
    check_val("rd_busy_nack", 32'(busy_o), 32'h0);
    i2c_stop();
    check_val("rd_req_pulses", 32'(rd_req_cnt - rd_base), 32'd2);
    check_val("rd_no_strobes", 32'(wr_log.size() - base), 32'd0);
    check_val("rd_ptr", 32'(reg_addr_o), 32'h42);

    // Address mismatch (0x51)
    base = wr_log.size();
    i2c_start();
    write_byte(8'hA2, ack);
    check_val("mis_nack", 32'(ack), 32'h1);
    check_val("mis_busy", 32'(busy_o), 32'h0);
    write_byte(8'h99, ack);
    check_val("mis_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    check_val("mis_no_strobes", 32'(wr_log.size() - base), 32'd0);

    // Abort after 4 data bits, then a clean write
    base = wr_log.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    send_bit(1'b1, dummy);
    send_bit(1'b0, dummy);
    send_bit(1'b1, dummy);
    send_bit(1'b1, dummy);
    i2c_stop();
    check_val("abort_no_strobe", 32'(wr_log.size() - base), 32'd0);
    check_val("abort_busy", 32'(busy_o), 32'h0);
    i2c_start();
    write_byte(8'hA0, ack);
    check_val("post_abort_ack", 32'(ack), 32'h0);
    write_byte(8'h05, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    check_val("post_abort_strobes", 32'(wr_log.size() - base), 32'd1);
    check_val("post_abort_strobe0", 32'(wr_log[base]), 32'h0577);
    check_val("post_abort_ptr", 32'(reg_addr_o), 32'h06);

    // Async reset while the slave drives the register-byte ACK
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, dummy);
    master_oe = 1'b0;
    wait_q();
    check_val("ack_driven", 32'(sda_bus), 32'h0);
    check_val("ack_reg_ptr", 32'(reg_addr_o), 32'h00);
    check_val("ack_busy", 32'(busy_o), 32'h1);
    #2;
    rst_i = 1'b0;
    #1;
    check_val("arst_sda", 32'(sda_bus), 32'h1);
    check_val("arst_busy", 32'(busy_o), 32'h0);
    check_val("arst_wr_data", 32'(wr_data_o), 32'h00);
    check_val("arst_wr_en", 32'(wr_en_o), 32'h0);
    check_val("arst_rd_req", 32'(rd_req_o), 32'h0);
    repeat (4) @(negedge clk_i);
    scl = 1'b1;
    rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check_val("post_rst_sda", 32'(sda_bus), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
